// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle controller driving a 16-bit data memory with programmable wait states
module mem_access_ctrl #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0]      wdata_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_datain,
  output logic                  mem_we_L,
  input  logic [WIDTH-1:0]      mem_dataout
);
  // one-hot so busy/done/we_L each decode from a single state flop
  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    WAIT   = 4'b0010,
    ACCESS = 4'b0100,
    DONE   = 4'b1000
  } state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  r_op;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [WIDTH-1:0]      r_mdr;
  logic [WIDTH-1:0]      r_rdata;
  logic                  w_idle;
  logic                  w_accept;
  assign w_idle   = r_state[0];
  assign w_accept = w_idle && (req_rd ^ req_wr);
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = (WS != 4'd0) ? WAIT : ACCESS;
      WAIT:    if (r_cnt <= 4'd1) w_next = ACCESS;
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_err   <= 1'b0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_rdata <= '0;
    end else begin
      r_err <= w_idle && req_rd && req_wr;
      if (w_accept) begin
        r_mar <= addr_in;
        r_op  <= req_wr;
        r_cnt <= WS;
        if (req_wr) r_mdr <= wdata_in;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ACCESS && !r_op) r_rdata <= mem_dataout;
    end
  assign busy       = ~w_idle;
  assign done       = r_state[3];
  assign err        = r_err;
  assign rdata      = r_rdata;
  assign mem_addr   = r_mar;
  assign mem_datain = r_mdr;
  assign mem_we_L   = ~(r_state[2] & r_op);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for a 1-wait-state instance (a) and a 0-wait-state instance (b), each with its own memory model
module tb_mem_access_ctrl;
  logic clock = 1'b0;
  logic reset_L = 1'b0;
  always #5 clock = ~clock;
  logic        rd[2], wr[2], busy[2], done[2], err[2], we_L[2];
  logic [15:0] addr[2], wdata[2], rdata[2], maddr[2], mdin[2], mdout[2];
  logic [15:0] mem[2][65536];
  int cyc = 0;
  int ndone[2] = '{0, 0};
  int errors = 0;
  int checks = 0;
  typedef struct {
    int          inst;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbq[$];
  mem_access_ctrl #(.WIDTH(16), .ADDR_WIDTH(16), .WAIT_STATES(1)) dut_a (
    .clock(clock), .reset_L(reset_L), .req_rd(rd[0]), .req_wr(wr[0]),
    .addr_in(addr[0]), .wdata_in(wdata[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .rdata(rdata[0]), .mem_addr(maddr[0]), .mem_datain(mdin[0]),
    .mem_we_L(we_L[0]), .mem_dataout(mdout[0])
  );
  mem_access_ctrl #(.WIDTH(16), .ADDR_WIDTH(16), .WAIT_STATES(0)) dut_b (
    .clock(clock), .reset_L(reset_L), .req_rd(rd[1]), .req_wr(wr[1]),
    .addr_in(addr[1]), .wdata_in(wdata[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .rdata(rdata[1]), .mem_addr(maddr[1]), .mem_datain(mdin[1]),
    .mem_we_L(we_L[1]), .mem_dataout(mdout[1])
  );
  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) if (!we_L[k]) mem[k][maddr[k]] <= mdin[k];
  end
  assign mdout[0] = mem[0][maddr[0]];
  assign mdout[1] = mem[1][maddr[1]];
  always @(negedge clock)
    for (int k = 0; k < 2; k++) if (done[k]) ndone[k] <= ndone[k] + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one request on instance i; the expected outcome is queued at issue and checked when done appears
  task automatic xact(input int i, input logic r, input logic w, input logic [15:0] ad,
                      input logic [15:0] wd, input logic [15:0] ex);
    int c0, got, weln, welc;
    exp_t e;
    @(negedge clock);
    rd[i] = r; wr[i] = w; addr[i] = ad; wdata[i] = wd;
    @(negedge clock);
    c0 = cyc;
    rd[i] = 1'b0; wr[i] = 1'b0;
    sbq.push_back('{i, ex, c0 + ((i == 0) ? 1 : 0) + 2});
    got = -1; weln = 0; welc = -1;
    for (int n = 0; n < 40 && got < 0; n++) begin
      if (!we_L[i]) begin weln++; welc = cyc + 1; end
      if (done[i]) got = cyc + 1;
      else @(negedge clock);
    end
    e = sbq.pop_front();
    chk($sformatf("done_cycle[%0d]", e.inst), got, e.cyc);
    chk($sformatf("rdata[%0d]", e.inst), rdata[i], e.rdata);
    chk($sformatf("busy_in_done[%0d]", e.inst), busy[i], 1'b1);
    if (w) begin
      chk($sformatf("we_low_count[%0d]", i), weln, 1);
      chk($sformatf("we_low_cycle[%0d]", i), welc, e.cyc - 1);
      @(negedge clock);
      chk($sformatf("mem_written[%0d]", i), mem[i][ad], wd);
    end else begin
      chk($sformatf("we_stays_high[%0d]", i), weln, 0);
      @(negedge clock);
    end
    chk($sformatf("idle_after[%0d]", i), busy[i], 1'b0);
  endtask
  initial begin
    int start;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_done", done[k], 1'b0);
      chk("rst_we_L", we_L[k], 1'b1);
      chk("rst_rdata", rdata[k], 16'h0000);
      chk("rst_addr", maddr[k], 16'h0000);
    end
    xact(0, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 16'h0000);
    xact(0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF);
    chk("addr_hold", maddr[0], 16'h1234);
    chk("wdata_hold", mdin[0], 16'hBEEF);
    xact(1, 1'b0, 1'b1, 16'h0000, 16'h00A5, 16'h0000);
    xact(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h00A5);
    @(negedge clock);
    rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'h0077; wdata[1] = 16'hDEAD;
    @(negedge clock);
    rd[1] = 1'b0; wr[1] = 1'b0;
    chk("err_pulse", err[1], 1'b1);
    chk("err_busy", busy[1], 1'b0);
    @(negedge clock);
    chk("err_cleared", err[1], 1'b0);
    chk("err_busy2", busy[1], 1'b0);
    chk("err_no_latch_addr", maddr[1], 16'h0000);
    chk("err_no_latch_data", mdin[1], 16'h00A5);
    chk("err_mem_kept", mem[1][0], 16'h00A5);
    start = ndone[0];
    @(negedge clock);
    wr[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'h1111;
    @(negedge clock);
    wr[0] = 1'b0; rd[0] = 1'b1; addr[0] = 16'h0020;
    chk("drop_in_wait", busy[0], 1'b1);
    @(negedge clock);
    chk("drop_access_we", we_L[0], 1'b0);
    @(negedge clock);
    rd[0] = 1'b0;
    chk("drop_done", done[0], 1'b1);
    repeat (4) @(negedge clock);
    chk("drop_one_done", ndone[0] - start, 1);
    chk("drop_rdata", rdata[0], 16'hBEEF);
    chk("drop_addr", maddr[0], 16'h0010);
    chk("drop_mem", mem[0][16'h0010], 16'h1111);
    chk("drop_idle", busy[0], 1'b0);
    xact(0, 1'b0, 1'b1, 16'h0040, 16'h5555, 16'hBEEF);
    start = ndone[0];
    @(negedge clock);
    wr[0] = 1'b1; addr[0] = 16'h0040; wdata[0] = 16'hCAFE;
    @(negedge clock);
    wr[0] = 1'b0;
    for (int n = 0; n < 10 && we_L[0]; n++) @(negedge clock);
    chk("abort_we_low_seen", we_L[0], 1'b0);
    #1 reset_L = 1'b0;
    #1;
    chk("abort_we_async", we_L[0], 1'b1);
    chk("abort_busy_async", busy[0], 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort_mem_kept", mem[0][16'h0040], 16'h5555);
    chk("abort_no_done", ndone[0] - start, 0);
    chk("abort_idle", busy[0], 1'b0);
    chk("abort_rdata_reset", rdata[0], 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
